// File: rtl/wbu_rf.sv
// -----------------------------------------------------------------------------
// wbu_rf -- writeback unit and register file for a small in-order RISC-V core.
//
// This block holds the GPR array, four machine CSRs (mcause, mepc, mstatus and
// mtvec) and a retire counter. A per-GPR busy scoreboard stalls issue while an
// older instruction still owes a result to a source or destination register.
// A writeback beat in flight is forwarded straight to the read ports in the
// cycle it is accepted, so a consumer never waits an extra cycle.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   issue_valid      decoder presents an instruction
//   issue_ready      instruction may issue this cycle (combinational)
//   issue_rs1/rs2    source GPR indices; values appear on rsa / rsb
//   issue_rd         destination GPR index
//   issue_wen        issued instruction will write issue_rd
//   rsa, rsb         source operand values, with same-cycle writeback bypass
//   csr_rs, csra     CSR read index and value, with same-cycle update bypass
//   wb_valid         writeback beat offered
//   wb_ready         writeback beat can be taken (high whenever out of reset)
//   wb_rd/wd/wen     GPR write request
//   wb_csr_rd/wd/wen CSR write request
//   wb_trap          beat traps: saves pc and cause, drops its GPR write
//   wb_mret          beat returns from trap (ignored when wb_trap is set)
//   wb_pc, wb_cause  pc and cause captured on a trap
//   retire_cnt       number of accepted beats, wrapping
// -----------------------------------------------------------------------------
module wbu_rf #(
  parameter int  XLEN = 32,
  parameter int  NREG = 32,
  parameter int  CNTW = 64,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wen,
  output logic [XLEN-1:0] rsa,
  output logic [XLEN-1:0] rsb,

  input  logic [1:0]      csr_rs,
  output logic [XLEN-1:0] csra,

  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            wb_wen,
  input  logic [1:0]      wb_csr_rd,
  input  logic [XLEN-1:0] wb_csr_wd,
  input  logic            wb_csr_wen,
  input  logic            wb_trap,
  input  logic            wb_mret,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_cause,

  output logic [CNTW-1:0] retire_cnt
);

  // Only RV32E (16) and full RV32I (32) register files are meaningful.
  if (NREG != 16 && NREG != 32) begin : g_bad_nreg
    $error("wbu_rf: NREG must be 16 or 32");
  end

  // Fixed CSR map.
  typedef enum logic [1:0] {
    CSR_MCAUSE  = 2'd0,
    CSR_MEPC    = 2'd1,
    CSR_MSTATUS = 2'd2,
    CSR_MTVEC   = 2'd3
  } csr_e;

  // mstatus bit positions.
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // Reset value has MPP = 2'b11 (machine mode) and interrupts disabled.
  localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] gpr [NREG];
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [CNTW-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Handshakes and write strobes
  // ---------------------------------------------------------------------------
  logic beat;        // writeback beat accepted this cycle
  logic gpr_we;      // beat actually writes a GPR
  logic busy_clr;    // beat releases busy[wb_rd]
  logic issue_fire;  // instruction issues this cycle
  logic busy_set;    // issue claims busy[issue_rd]

  // The writeback side never backpressures; it only refuses beats in reset.
  assign wb_ready = rst;
  assign beat     = wb_valid & wb_ready;

  // A trapping beat does not commit its result, but the instruction is done,
  // so its destination must still be released or issue would deadlock.
  assign gpr_we   = beat & wb_wen & ~wb_trap & (wb_rd != '0);
  assign busy_clr = beat & wb_wen;

  assign issue_fire = issue_valid & issue_ready;
  assign busy_set   = issue_fire & issue_wen & (issue_rd != '0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] eff_busy;  // busy, minus the register this beat releases
  logic [NREG-1:0] busy_n;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    eff_busy = busy;
    if (busy_clr) eff_busy[wb_rd] = 1'b0;
  end

  // A register released this cycle is forwarded to the read ports, so it no
  // longer needs to stall the consumer.
  always_comb begin
    issue_ready = 1'b1;
    if (eff_busy[issue_rs1] || eff_busy[issue_rs2]) issue_ready = 1'b0;
    if (issue_wen && eff_busy[issue_rd])            issue_ready = 1'b0;
  end

  // Set is applied after clear: a younger writer issuing to the same register
  // in the cycle the older one retires keeps the register reserved.
  always_comb begin
    busy_n = busy;
    if (busy_clr) busy_n[wb_rd]    = 1'b0;
    if (busy_set) busy_n[issue_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // GPR read ports with writeback bypass. x0 is never written, so the array
  // entry holds zero and the bypass never targets index 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsa = gpr[issue_rs1];
    rsb = gpr[issue_rs2];
    if (gpr_we && (wb_rd == issue_rs1)) rsa = wb_wd;
    if (gpr_we && (wb_rd == issue_rs2)) rsb = wb_wd;
  end

  // ---------------------------------------------------------------------------
  // CSR next-state. Without an accepted beat the next values equal the current
  // ones, so reading through them gives the same-cycle bypass for free.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mcause_n;
  logic [XLEN-1:0] mepc_n;
  logic [XLEN-1:0] mstatus_n;
  logic [XLEN-1:0] mtvec_n;
  logic            csr_wr;

  // Trap and mret own mcause, mepc and mstatus on their beat; only an mtvec
  // write may ride along with them.
  assign csr_wr = beat & wb_csr_wen &
                  (~(wb_trap | wb_mret) | (csr_e'(wb_csr_rd) == CSR_MTVEC));

  always_comb begin
    mcause_n  = mcause;
    mepc_n    = mepc;
    mstatus_n = mstatus;
    mtvec_n   = mtvec;

    if (csr_wr) begin
      unique case (csr_e'(wb_csr_rd))
        CSR_MCAUSE:  mcause_n  = wb_csr_wd;
        CSR_MEPC:    mepc_n    = wb_csr_wd;
        CSR_MSTATUS: mstatus_n = wb_csr_wd;
        CSR_MTVEC:   mtvec_n   = wb_csr_wd;
        default:     ;
      endcase
    end

    if (beat && wb_trap) begin
      mepc_n              = wb_pc;
      mcause_n            = wb_cause;
      mstatus_n[MPIE_BIT] = mstatus[MIE_BIT];
      mstatus_n[MIE_BIT]  = 1'b0;
    end else if (beat && wb_mret) begin
      mstatus_n[MIE_BIT]  = mstatus[MPIE_BIT];
      mstatus_n[MPIE_BIT] = 1'b1;
    end
  end

  always_comb begin
    csra = mcause_n;
    unique case (csr_e'(csr_rs))
      CSR_MCAUSE:  csra = mcause_n;
      CSR_MEPC:    csra = mepc_n;
      CSR_MSTATUS: csra = mstatus_n;
      CSR_MTVEC:   csra = mtvec_n;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: the GPR array is cleared by the asynchronous reset, which rules out
  // mapping it onto a RAM macro; it is built from flops on purpose because
  // every register must read zero the moment reset asserts.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      busy    <= '0;
      mcause  <= '0;
      mepc    <= '0;
      mstatus <= MSTATUS_RST;
      mtvec   <= '0;
      cnt     <= '0;
    end else begin
      if (gpr_we) gpr[wb_rd] <= wb_wd;
      busy    <= busy_n;
      mcause  <= mcause_n;
      mepc    <= mepc_n;
      mstatus <= mstatus_n;
      mtvec   <= mtvec_n;
      if (beat) cnt <= cnt + CNTW'(1);
    end
  end

  assign retire_cnt = cnt;

endmodule

// File: tb/tb_wbu_rf.sv
// -----------------------------------------------------------------------------
// tb_wbu_rf -- directed, table-driven bench for wbu_rf.
//
// Each table row is one clock cycle: inputs are driven just after the rising
// edge, the combinational outputs and retire count are compared mid-cycle,
// then the edge commits the row. A hand-written sequence afterwards covers
// asynchronous reset in the middle of a cycle. A second instance with a 3-bit
// retire counter shares all inputs and shows the counter wrapping.
// -----------------------------------------------------------------------------
module tb_wbu_rf;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_wen;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [1:0]  csr_rs;
  logic [31:0] csra;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        wb_wen;
  logic [1:0]  wb_csr_rd;
  logic [31:0] wb_csr_wd;
  logic        wb_csr_wen;
  logic        wb_trap;
  logic        wb_mret;
  logic [31:0] wb_pc;
  logic [31:0] wb_cause;
  logic [63:0] retire_cnt;

  // Outputs of the narrow-counter instance.
  logic        issue_ready_w;
  logic [31:0] rsa_w;
  logic [31:0] rsb_w;
  logic [31:0] csra_w;
  logic        wb_ready_w;
  logic [2:0]  retire_cnt_w;

  wbu_rf dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .rsa(rsa), .rsb(rsb),
    .csr_rs(csr_rs), .csra(csra),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_wen(wb_wen),
    .wb_csr_rd(wb_csr_rd), .wb_csr_wd(wb_csr_wd), .wb_csr_wen(wb_csr_wen),
    .wb_trap(wb_trap), .wb_mret(wb_mret), .wb_pc(wb_pc), .wb_cause(wb_cause),
    .retire_cnt(retire_cnt)
  );

  wbu_rf #(.CNTW(3)) dut_w (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready_w),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .rsa(rsa_w), .rsb(rsb_w),
    .csr_rs(csr_rs), .csra(csra_w),
    .wb_valid(wb_valid), .wb_ready(wb_ready_w),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_wen(wb_wen),
    .wb_csr_rd(wb_csr_rd), .wb_csr_wd(wb_csr_wd), .wb_csr_wen(wb_csr_wen),
    .wb_trap(wb_trap), .wb_mret(wb_mret), .wb_pc(wb_pc), .wb_cause(wb_cause),
    .retire_cnt(retire_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected before its clock edge.
  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        iwen;
    logic [1:0]  csr;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wwd;
    logic        wwen;
    logic [1:0]  wcrd;
    logic [31:0] wcwd;
    logic        wcwen;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        e_ready;
    logic [31:0] e_rsa;
    logic [31:0] e_rsb;
    logic [31:0] e_csra;
    logic [63:0] e_cnt;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_wen = 1'b0;
    csr_rs = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_wd = '0; wb_wen = 1'b0;
    wb_csr_rd = '0; wb_csr_wd = '0; wb_csr_wen = 1'b0;
    wb_trap = 1'b0; wb_mret = 1'b0; wb_pc = '0; wb_cause = '0;
  endtask

  task automatic apply(input vec_t v);
    issue_valid = v.iv;  issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rd = v.rd;
    issue_wen   = v.iwen; csr_rs = v.csr;
    wb_valid  = v.wv;   wb_rd = v.wrd; wb_wd = v.wwd; wb_wen = v.wwen;
    wb_csr_rd = v.wcrd; wb_csr_wd = v.wcwd; wb_csr_wen = v.wcwen;
    wb_trap   = v.trap; wb_mret = v.mret; wb_pc = v.pc; wb_cause = v.cause;
  endtask

  initial begin
    //        iv    rs1   rs2   rd    iwen  csr    wv    wrd   wwd            wwen  wcrd   wcwd           wcwen trap  mret  pc             cause    | ready rsa        rsb        csra           cnt
    // Reset state: mstatus reads its reset value, nothing busy.
    vecs[0]  = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd2, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h1800,     64'd0};
    // Issue a writer of x5.
    vecs[1]  = '{1'b1,5'd0,5'd0,5'd5,1'b1,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h0,        64'd0};
    // Consumer of x5 stalls.
    vecs[2]  = '{1'b1,5'd5,5'd0,5'd0,1'b0,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b0,32'h0,    32'h0,    32'h0,        64'd0};
    // x5 retires in the same cycle: stall lifts, value is bypassed.
    vecs[3]  = '{1'b1,5'd5,5'd0,5'd0,1'b0,2'd0, 1'b1,5'd5,32'hDEAD,     1'b1,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'hDEAD, 32'h0,    32'h0,        64'd0};
    // Array now holds x5.
    vecs[4]  = '{1'b0,5'd5,5'd5,5'd0,1'b0,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'hDEAD, 32'hDEAD, 32'h0,        64'd1};
    // Write to x0 is neither bypassed nor stored; rd=0 never blocks.
    vecs[5]  = '{1'b1,5'd0,5'd5,5'd0,1'b1,2'd0, 1'b1,5'd0,32'hFFFF_FFFF,1'b1,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'hDEAD, 32'h0,        64'd1};
    vecs[6]  = '{1'b1,5'd0,5'd0,5'd0,1'b1,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h0,        64'd2};
    // CSR write mstatus=0x1808 (MIE set), bypassed onto csra.
    vecs[7]  = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd2, 1'b1,5'd0,32'h0,        1'b0,2'd2,32'h1808,     1'b1,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h1808,     64'd2};
    // Trap beat with a GPR write to x9: MPIE<-MIE, MIE<-0; x9 not written.
    vecs[8]  = '{1'b0,5'd9,5'd0,5'd0,1'b0,2'd2, 1'b1,5'd9,32'h1234,     1'b1,2'd0,32'h0,        1'b0,1'b1,1'b0,32'h8000_0010,32'd11, 1'b1,32'h0,    32'h0,    32'h1880,     64'd3};
    vecs[9]  = '{1'b0,5'd9,5'd0,5'd0,1'b0,2'd1, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h8000_0010,64'd4};
    vecs[10] = '{1'b0,5'd9,5'd0,5'd0,1'b0,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'd11,       64'd4};
    // mret from 0x1880: MIE<-MPIE (1) and MPIE<-1, giving 0x1888.
    vecs[11] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd2, 1'b1,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b1,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h1888,     64'd4};
    // Trap and mret together, plus a competing mstatus write: trap only.
    vecs[12] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd2, 1'b1,5'd0,32'h0,        1'b0,2'd2,32'h0000_FFFF,1'b1,1'b1,1'b1,32'h100,      32'd3,  1'b1,32'h0,    32'h0,    32'h1880,     64'd5};
    // Trap with an mtvec write: the mtvec write still lands.
    vecs[13] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd3, 1'b1,5'd0,32'h0,        1'b0,2'd3,32'h200,      1'b1,1'b1,1'b0,32'h104,      32'd7,  1'b1,32'h0,    32'h0,    32'h200,      64'd6};
    vecs[14] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd2, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h1800,     64'd7};
    vecs[15] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd1, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h104,      64'd7};
    vecs[16] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'd7,        64'd7};
    // Plain CSR write to mepc.
    vecs[17] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd1, 1'b1,5'd0,32'h0,        1'b0,2'd1,32'hABC,      1'b1,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'hABC,      64'd7};
    vecs[18] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd3, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'h200,      64'd8};
    vecs[19] = '{1'b0,5'd0,5'd0,5'd0,1'b0,2'd1, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'hABC,      64'd8};
    // WAW: claim x7, then reissue x7 while the beat releases it (set wins).
    vecs[20] = '{1'b1,5'd0,5'd0,5'd7,1'b1,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h0,    32'h0,    32'd7,        64'd8};
    vecs[21] = '{1'b1,5'd7,5'd0,5'd7,1'b1,2'd0, 1'b1,5'd7,32'h77,       1'b1,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b1,32'h77,   32'h0,    32'd7,        64'd8};
    // x7 still busy for the second writer: both a writer and a reader stall.
    vecs[22] = '{1'b1,5'd7,5'd0,5'd7,1'b1,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b0,32'h77,   32'h0,    32'd7,        64'd9};
    vecs[23] = '{1'b1,5'd0,5'd7,5'd0,1'b0,2'd0, 1'b0,5'd0,32'h0,        1'b0,2'd0,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'd0,  1'b0,32'h0,    32'h77,   32'd7,        64'd9};

    idle_inputs();
    rst = 1'b0;
    #1;
    check("reset wb_ready", {63'd0, wb_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      #3;
      check($sformatf("row%0d issue_ready", i), {63'd0, issue_ready}, {63'd0, vecs[i].e_ready});
      check($sformatf("row%0d rsa", i),         {32'd0, rsa},         {32'd0, vecs[i].e_rsa});
      check($sformatf("row%0d rsb", i),         {32'd0, rsb},         {32'd0, vecs[i].e_rsb});
      check($sformatf("row%0d csra", i),        {32'd0, csra},        {32'd0, vecs[i].e_csra});
      check($sformatf("row%0d retire_cnt", i),  retire_cnt,           vecs[i].e_cnt);
      check($sformatf("row%0d wb_ready", i),    {63'd0, wb_ready},    64'd1);
      @(posedge clk);
      #1;
    end

    // Nine beats retired; the 3-bit counter has wrapped to 1.
    idle_inputs();
    #1;
    check("wrap retire_cnt", {61'd0, retire_cnt_w}, 64'd1);
    check("wide retire_cnt", retire_cnt, 64'd9);

    // --- Mid-cycle asynchronous reset with busy bits pending ---------------
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    // Claim x3, and clear mstatus so its reset value is visible later.
    issue_valid = 1'b1; issue_rd = 5'd3; issue_wen = 1'b1;
    wb_valid = 1'b1; wb_csr_wen = 1'b1; wb_csr_rd = 2'd2; wb_csr_wd = 32'h0;
    @(posedge clk);
    #1;
    // Claim x4, write x10.
    issue_rd = 5'd4;
    wb_csr_wen = 1'b0; wb_wen = 1'b1; wb_rd = 5'd10; wb_wd = 32'h55;
    @(posedge clk);
    #1;
    // Third beat with no write.
    issue_valid = 1'b0; issue_wen = 1'b0; wb_wen = 1'b0;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    issue_rs1 = 5'd3; issue_rs2 = 5'd10; issue_rd = 5'd4; issue_wen = 1'b1; csr_rs = 2'd2;
    #1;
    check("pre-reset retire_cnt", retire_cnt, 64'd3);
    check("pre-reset issue_ready", {63'd0, issue_ready}, 64'd0);
    check("pre-reset mstatus", {32'd0, csra}, 64'h0);
    check("pre-reset x10", {32'd0, rsb}, 64'h55);
    #1 rst = 1'b0;
    #1;
    check("async rst retire_cnt", retire_cnt, 64'd0);
    check("async rst wb_ready", {63'd0, wb_ready}, 64'd0);
    check("async rst issue_ready", {63'd0, issue_ready}, 64'd1);
    check("async rst mstatus", {32'd0, csra}, 64'h1800);
    check("async rst x10", {32'd0, rsb}, 64'h0);
    check("async rst wrap cnt", {61'd0, retire_cnt_w}, 64'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset wb_ready", {63'd0, wb_ready}, 64'd1);
    check("post-reset issue_ready", {63'd0, issue_ready}, 64'd1);
    check("post-reset retire_cnt", retire_cnt, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
